// File: rtl/intersection_phase_arbiter_pkg.sv
// Shared types and constants for the intersection phase arbiter.
// Defines the phase enum, the default timing values (in ticks) and the approach count.
package intersection_phase_arbiter_pkg;

  localparam int unsigned NumApproach = 4;

  localparam int unsigned DefMinGreen = 4;
  localparam int unsigned DefMaxGreen = 10;
  localparam int unsigned DefYellowT  = 2;
  localparam int unsigned DefAllRedT  = 1;
  localparam int unsigned DefWalkT    = 3;

  typedef enum logic [1:0] {
    StGreen,
    StYellow,
    StAllRed,
    StWalk
  } phase_e;

  function automatic int unsigned max_of(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/intersection_phase_arbiter_if.sv
// Signal bundle between the arbiter and its environment.
//   tick      : one-cycle timing enable
//   req       : per-approach vehicle presence (level)
//   ped_req   : pedestrian button (level or pulse)
//   green/yellow/red : per-approach lamps
//   ped_walk  : walk signal
//   grant_idx : approach that owns, or last owned, the phase
// master = environment/bench side, slave = arbiter side.
interface intersection_phase_arbiter_if;
  import intersection_phase_arbiter_pkg::*;

  logic                   tick;
  logic [NumApproach-1:0] req;
  logic                   ped_req;
  logic [NumApproach-1:0] green;
  logic [NumApproach-1:0] yellow;
  logic [NumApproach-1:0] red;
  logic                   ped_walk;
  logic [1:0]             grant_idx;

  modport master (
    output tick, req, ped_req,
    input  green, yellow, red, ped_walk, grant_idx
  );

  modport slave (
    input  tick, req, ped_req,
    output green, yellow, red, ped_walk, grant_idx
  );

endinterface

// File: rtl/intersection_phase_arbiter_phase_rr_picker.sv
// Combinational round-robin picker over the pending approaches.
//   pending_i : latched requests per approach
//   last_i    : approach granted most recently
//   valid_o   : at least one approach is pending
//   idx_o     : first pending approach searching from last_i+1 with wrap
//               (last_i when nothing is pending)
module intersection_phase_arbiter_phase_rr_picker
  import intersection_phase_arbiter_pkg::*;
(
  input  logic [NumApproach-1:0] pending_i,
  input  logic [1:0]             last_i,
  output logic                   valid_o,
  output logic [1:0]             idx_o
);

  logic [1:0] cand;

  always_comb begin
    valid_o = 1'b0;
    idx_o   = last_i;
    cand    = '0;
    // k = NumApproach lands back on last_i, so the last owner is considered last.
    for (int unsigned k = 1; k <= NumApproach; k++) begin
      cand = last_i + 2'(k);
      if (!valid_o && pending_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/intersection_phase_arbiter.sv
// Four-approach intersection controller: round-robin green phase with
// min/max green, yellow, all-red clearance and an optional pedestrian walk.
// All timing is counted in ticks. Outputs decode registered state only.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   ctl   : slave side of intersection_phase_arbiter_if
module intersection_phase_arbiter
  import intersection_phase_arbiter_pkg::*;
#(
  parameter int unsigned MIN_GREEN = DefMinGreen,
  parameter int unsigned MAX_GREEN = DefMaxGreen,
  parameter int unsigned YELLOW_T  = DefYellowT,
  parameter int unsigned ALL_RED_T = DefAllRedT,
  parameter int unsigned WALK_T    = DefWalkT
) (
  input logic                        clk,
  input logic                        rst_n,
  intersection_phase_arbiter_if.slave ctl
);

  localparam int unsigned MaxT =
      max_of(max_of(MIN_GREEN, MAX_GREEN), max_of(max_of(YELLOW_T, ALL_RED_T), WALK_T));
  localparam int unsigned TimerW = $clog2(MaxT) + 1;

  typedef logic [TimerW-1:0] timer_t;

  localparam timer_t MinGreenEnd = timer_t'(MIN_GREEN - 1);
  localparam timer_t MaxGreenEnd = timer_t'(MAX_GREEN - 1);
  localparam timer_t YellowEnd   = timer_t'(YELLOW_T - 1);
  localparam timer_t AllRedEnd   = timer_t'(ALL_RED_T - 1);
  localparam timer_t WalkEnd     = timer_t'(WALK_T - 1);

  phase_e                 state_q, state_d;
  logic [1:0]             grant_q, grant_d;
  timer_t                 timer_q, timer_d;
  logic [NumApproach-1:0] pending_q, pending_d;
  logic                   ped_pending_q, ped_pending_d;
  logic                   ped_done_q, ped_done_d;

  logic                   rr_valid;
  logic [1:0]             rr_idx;
  logic                   grant_now;
  logic                   walk_entry;
  logic [NumApproach-1:0] grant_oh;
  logic [NumApproach-1:0] set_mask;
  logic [NumApproach-1:0] clr_mask;

  intersection_phase_arbiter_phase_rr_picker u_picker (
    .pending_i (pending_q),
    .last_i    (grant_q),
    .valid_o   (rr_valid),
    .idx_o     (rr_idx)
  );

  assign grant_oh = NumApproach'(1) << grant_q;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ped_done_d = ped_done_q;
    grant_now  = 1'b0;
    walk_entry = 1'b0;
    unique case (state_q)
      StGreen: begin
        // >= on the max bound so a late request is still served once the
        // timer has saturated past MAX_GREEN-1.
        if (ctl.tick && (timer_q >= MinGreenEnd) && ((|pending_q) || ped_pending_q) &&
            (!ctl.req[grant_q] || (timer_q >= MaxGreenEnd))) begin
          state_d = StYellow;
        end
      end
      StYellow: begin
        if (ctl.tick && (timer_q == YellowEnd)) state_d = StAllRed;
      end
      StAllRed: begin
        if (ctl.tick && (timer_q == AllRedEnd)) begin
          if (ped_pending_q && !ped_done_q) begin
            state_d    = StWalk;
            walk_entry = 1'b1;
          end else begin
            state_d    = StGreen;
            grant_now  = 1'b1;
            ped_done_d = 1'b0;
            if (rr_valid) grant_d = rr_idx;
          end
        end
      end
      StWalk: begin
        if (ctl.tick && (timer_q == WalkEnd)) begin
          state_d    = StAllRed;
          ped_done_d = 1'b1;
        end
      end
      default: state_d = StGreen;
    endcase
  end

  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (ctl.tick && (timer_q != '1)) begin
      timer_d = timer_q + timer_t'(1);
    end
  end

  // The current owner's own request only matters while it is green; at any
  // other time it is a fresh demand for another turn.
  always_comb begin
    set_mask      = ctl.req & ~((state_q == StGreen) ? grant_oh : '0);
    clr_mask      = grant_now ? (NumApproach'(1) << grant_d) : '0;
    pending_d     = (pending_q | set_mask) & ~clr_mask;
    ped_pending_d = (ped_pending_q | (ctl.ped_req && (state_q != StWalk))) && !walk_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StGreen;
      grant_q       <= '0;
      timer_q       <= '0;
      pending_q     <= '0;
      ped_pending_q <= 1'b0;
      ped_done_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      timer_q       <= timer_d;
      pending_q     <= pending_d;
      ped_pending_q <= ped_pending_d;
      ped_done_q    <= ped_done_d;
    end
  end

  assign ctl.green     = (state_q == StGreen)  ? grant_oh : '0;
  assign ctl.yellow    = (state_q == StYellow) ? grant_oh : '0;
  assign ctl.red       = ~ctl.green & ~ctl.yellow;
  assign ctl.ped_walk  = (state_q == StWalk);
  assign ctl.grant_idx = grant_q;

endmodule

// File: doc/intersection_phase_arbiter.md
Name: intersection_phase_arbiter

Overview:
- Four-approach intersection controller. Shares one green phase among approaches 0-3 using round-robin, plus an optional pedestrian walk phase.
- Enforces minimum green, maximum green extension, yellow and all-red clearance timing. All timing counts in ticks of an external enable.
- Sits above the per-road light drivers: drives their red/yellow/green lamps directly and is fed by vehicle sensors and a push button.

Parameters:
- MIN_GREEN, 4: minimum green length, in ticks.
- MAX_GREEN, 10: maximum green length while the own request extends it, in ticks (must be >= MIN_GREEN).
- YELLOW_T, 2: yellow length, in ticks.
- ALL_RED_T, 1: all-red clearance length, in ticks.
- WALK_T, 3: pedestrian walk length, in ticks.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle timing enable; timers advance only when tick=1.
- req  in  4  vehicle presence per approach, level-sensitive.
- ped_req  in  1  pedestrian button, level or pulse.
- green  out  4  one-hot green lamp per approach.
- yellow  out  4  one-hot yellow lamp per approach.
- red  out  4  red lamp per approach; red[i] = ~green[i] & ~yellow[i].
- ped_walk  out  1  walk signal.
- grant_idx  out  2  index of the approach that currently owns or last owned the phase.

Behaviour:
- One clock; reset is asynchronous and active-low (clk, reset).
- Reset values: state=GREEN, grant_idx=0, green=4'b0001, yellow=0, red=4'b1110, ped_walk=0, timer=0, pending=0, ped_pending=0.
- Outputs are registered-state decoded (Moore) with no combinational path from inputs.
- Request latching:
  - pending[i] sets when req[i]=1, except when i==grant_idx and state is GREEN.
  - ped_pending sets on ped_req=1 in any state except WALK.
  - Latching is independent of tick.
  - pending[i] clears on the cycle approach i is granted. If clear and set coincide, clear wins, because i is now green.
  - ped_pending clears on entry to WALK.
- Timer:
  - Reset to 0 on every state entry; increments on tick.
  - A state of length D exits on the tick where timer==D-1, so it lasts exactly D ticks.
  - Width is clog2(max param)+1; the timer saturates and never wraps.
- States:
  - GREEN: green[grant_idx]=1. Once timer >= MIN_GREEN-1 on a tick, go to YELLOW if (pending≠0 or ped_pending) and (req[grant_idx]=0 or timer==MAX_GREEN-1). Otherwise hold. With nothing pending, the block rests in green indefinitely and the timer saturates.
  - YELLOW: yellow[grant_idx]=1, lasts YELLOW_T ticks -> ALL_RED.
  - ALL_RED: all red, lasts ALL_RED_T ticks. Exit to WALK if ped_pending and the walk has not yet been served in this cycle (flag ped_done=0). Otherwise grant the next approach by round-robin and go to GREEN.
  - WALK: all red, ped_walk=1, lasts WALK_T ticks -> ALL_RED with ped_done=1. ped_done clears on GREEN entry.
- Round-robin:
  - Search starts at grant_idx+1 mod 4 and wraps; the first pending approach wins.
  - If nothing is pending after a walk, re-grant the same grant_idx.
- tick=0 freezes all timing; state never changes without a tick.
- Reset asserted mid-phase (e.g., YELLOW or WALK) returns to the reset values immediately, asynchronously; latched requests are lost.
- Invariant: at most one of green/yellow is set across all approaches, and never together with ped_walk.

Decomposition:
- Shared package tlc_pkg:
  - state enum {GREEN, YELLOW, ALL_RED, WALK};
  - default timing constants;
  - NUM_APPROACH=4.
- One sub-module, phase_rr_picker: combinational 4-bit round-robin picker. Inputs pending[3:0] and last[1:0]; outputs valid and idx[1:0]. It is unit-testable standalone.
- Timer and FSM stay in the top module.

Test Plan (tick=1 every cycle, default parameters):
- Reset released, req=0, ped_req=0 for 30 cycles -> green=0001, red=1110 throughout; ped_walk=0.
- req[2] pulsed 1 cycle at cycle 1 -> green[0] for cycles 0-3, yellow[0] for cycles 4-5, all red at cycle 6, green[2] from cycle 7; grant_idx=2.
- req[1] and req[3] pulsed together while approach 0 is green -> grant order 1 then 3, each with min-green 4, yellow 2 and all-red 1.
- req[0] held high, req[1] pulsed at cycle 0 -> green[0] lasts 10 cycles (MAX_GREEN), then yellow 2, all-red 1, green[1].
- ped_req and req[1] pulsed at cycle 0 -> green0 4, yellow 2, all-red 1, ped_walk 3, all-red 1, then green[1].
- Reset asserted during yellow[0] with tick=0 -> outputs return to reset values asynchronously; after release green=0001 and the earlier request is not served.
